// File: rtl/hdmi_window_capture.sv
// Captures a rectangular window of decoded HDMI pixels into a downstream FIFO.
// Define HDMI_CAP_STATS_EN to enable frame_count, drop_count and short_frame (tied to 0 otherwise).
module hdmi_window_capture #(
    parameter int PIXEL_W    = 8,
    parameter int WIN_WIDTH  = 64,
    parameter int WIN_HEIGHT = 64,
    parameter int X_OFFSET   = 0,
    parameter int Y_OFFSET   = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   hsync,
    input  logic                   vsync,
    input  logic                   de,
    input  logic                   red_vld,
    input  logic                   green_vld,
    input  logic                   blue_vld,
    input  logic                   red_rdy,
    input  logic                   green_rdy,
    input  logic                   blue_rdy,
    input  logic [PIXEL_W-1:0]     red,
    input  logic [PIXEL_W-1:0]     green,
    input  logic [PIXEL_W-1:0]     blue,
    input  logic                   enable,
    input  logic                   single_shot,
    input  logic                   clear,
    input  logic                   fifo_full,
    output logic [3*PIXEL_W-1:0]   fifo_data,
    output logic                   fifo_wr_en,
    output logic                   busy,
    output logic                   capture_done,
    output logic                   overflow,
    output logic                   short_frame,
    output logic [15:0]            frame_count,
    output logic [15:0]            drop_count
);

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_WAIT_FRAME = 2'd1;
    localparam logic [1:0] ST_CAPTURE    = 2'd2;
    localparam logic [1:0] ST_DONE       = 2'd3;

    localparam logic [16:0] X_LO   = 17'(X_OFFSET);
    localparam logic [16:0] X_HI   = 17'(X_OFFSET + WIN_WIDTH);
    localparam logic [16:0] Y_LO   = 17'(Y_OFFSET);
    localparam logic [16:0] Y_HI   = 17'(Y_OFFSET + WIN_HEIGHT);
    localparam logic [15:0] Y_LAST = 16'(Y_OFFSET + WIN_HEIGHT - 1);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [1:0]  state;
    logic        vsync_p1;
    logic        de_p1;
    logic [15:0] x_cnt;
    logic [15:0] y_cnt;
    logic        link_ok;
    logic        run;
    logic        frame_start;
    logic        line_end;
    logic        x_in;
    logic        y_in;
    logic        in_win;
    logic        frame_done;
    logic        unused_ok;

    // hsync carries no information beyond what de already gives us
    assign unused_ok   = hsync;
    assign link_ok     = &{red_vld, green_vld, blue_vld, red_rdy, green_rdy, blue_rdy};
    assign run         = link_ok & enable;
    assign frame_start = vsync & ~vsync_p1;
    assign line_end    = ~de & de_p1;
    assign x_in        = ({1'b0, x_cnt} >= X_LO) && ({1'b0, x_cnt} < X_HI);
    assign y_in        = ({1'b0, y_cnt} >= Y_LO) && ({1'b0, y_cnt} < Y_HI);
    assign in_win      = run && (state == ST_CAPTURE) && de && x_in && y_in;
    assign frame_done  = run && (state == ST_CAPTURE) && !frame_start && line_end && (y_cnt == Y_LAST);
    assign busy         = (state == ST_WAIT_FRAME) || (state == ST_CAPTURE);
    assign capture_done = (state == ST_DONE);

    // Sync edge detection and raster position
    always_ff @(posedge clk) begin
        if (!reset) begin
            vsync_p1 <= 1'b0;
            de_p1    <= 1'b0;
            x_cnt    <= '0;
            y_cnt    <= '0;
        end else begin
            vsync_p1 <= vsync;
            de_p1    <= de;
            if (frame_start || line_end) x_cnt <= '0;
            else if (de)                 x_cnt <= sat_inc(x_cnt);
            if (frame_start)   y_cnt <= '0;
            else if (line_end) y_cnt <= sat_inc(y_cnt);
        end
    end

    // Control FSM, write strobe and overflow flag; losing link or enable aborts immediately
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            fifo_wr_en <= 1'b0;
            fifo_data  <= '0;
            overflow   <= 1'b0;
        end else begin
            fifo_wr_en <= in_win & ~fifo_full;
            if (in_win && !fifo_full) fifo_data <= {red, green, blue};
            if (clear)                overflow  <= 1'b0;
            if (in_win && fifo_full)  overflow  <= 1'b1;
            if (!run) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE:       state <= ST_WAIT_FRAME;
                    ST_WAIT_FRAME: if (frame_start) state <= ST_CAPTURE;
                    ST_CAPTURE:    if (frame_done) state <= single_shot ? ST_DONE : ST_WAIT_FRAME;
                    default:       state <= state;
                endcase
            end
        end
    end

`ifdef HDMI_CAP_STATS_EN
    logic [15:0] frame_cnt_q;
    logic [15:0] drop_cnt_q;
    logic        short_q;

    // A new frame arriving mid-capture just restarts the counters; the FSM stays in CAPTURE
    always_ff @(posedge clk) begin
        if (!reset) begin
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
            short_q     <= 1'b0;
        end else begin
            if (frame_done) frame_cnt_q <= frame_cnt_q + 16'd1;
            if (clear) begin
                drop_cnt_q <= '0;
                short_q    <= 1'b0;
            end
            if (in_win && fifo_full) drop_cnt_q <= sat_inc(drop_cnt_q);
            if (run && (state == ST_CAPTURE) && frame_start) short_q <= 1'b1;
        end
    end

    assign frame_count = frame_cnt_q;
    assign drop_count  = drop_cnt_q;
    assign short_frame = short_q;
`else
    assign frame_count = '0;
    assign drop_count  = '0;
    assign short_frame = 1'b0;
`endif

endmodule

// File: tb/tb_hdmi_window_capture.sv
// Scoreboard bench for hdmi_window_capture: a 64x4 window at offset 0 and a 4x2 window at (10,2),
// both fed the same 128x16 raster.
module tb_hdmi_window_capture;

`ifdef HDMI_CAP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, hsync, vsync, de;
    logic red_vld, green_vld, blue_vld, red_rdy, green_rdy, blue_rdy;
    logic [7:0] red, green, blue;
    logic enable, single_shot, clear, fifo_full;

    logic [23:0] data_a, data_b;
    logic wr_a, busy_a, done_a, ovf_a, short_a;
    logic wr_b, busy_b, done_b, ovf_b, short_b;
    logic [15:0] fc_a, dc_a, fc_b, dc_b;

    always #5 clk = ~clk;

    hdmi_window_capture #(.PIXEL_W(8), .WIN_WIDTH(64), .WIN_HEIGHT(4), .X_OFFSET(0), .Y_OFFSET(0)) u_a (
        .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .de(de),
        .red_vld(red_vld), .green_vld(green_vld), .blue_vld(blue_vld),
        .red_rdy(red_rdy), .green_rdy(green_rdy), .blue_rdy(blue_rdy),
        .red(red), .green(green), .blue(blue),
        .enable(enable), .single_shot(single_shot), .clear(clear), .fifo_full(fifo_full),
        .fifo_data(data_a), .fifo_wr_en(wr_a), .busy(busy_a), .capture_done(done_a),
        .overflow(ovf_a), .short_frame(short_a), .frame_count(fc_a), .drop_count(dc_a)
    );

    hdmi_window_capture #(.PIXEL_W(8), .WIN_WIDTH(4), .WIN_HEIGHT(2), .X_OFFSET(10), .Y_OFFSET(2)) u_b (
        .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .de(de),
        .red_vld(red_vld), .green_vld(green_vld), .blue_vld(blue_vld),
        .red_rdy(red_rdy), .green_rdy(green_rdy), .blue_rdy(blue_rdy),
        .red(red), .green(green), .blue(blue),
        .enable(enable), .single_shot(single_shot), .clear(clear), .fifo_full(fifo_full),
        .fifo_data(data_b), .fifo_wr_en(wr_b), .busy(busy_b), .capture_done(done_b),
        .overflow(ovf_b), .short_frame(short_b), .frame_count(fc_b), .drop_count(dc_b)
    );

    int checks = 0;
    int errors = 0;
    logic [23:0] q_a[$];
    logic [23:0] q_b[$];
    logic [23:0] exp_a, exp_b;
    int wr_cnt_a = 0;
    int wr_cnt_b = 0;
    int base_a, base_b;
    int fid = 0;
    bit cap_on = 1'b0;
    int full_left = 0;
    int kill_line = -1;
    int kill_x = -1;
    bit chk_idle = 1'b0;
    bit watch_cont = 1'b0;
    int cont_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe pops the oldest expected pixel of that instance
    always @(negedge clk) begin
        if (wr_a === 1'b1) begin
            wr_cnt_a++;
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_write got %06h expected no write", data_a);
            end else begin
                exp_a = q_a.pop_front();
                check("a_data", 32'(data_a), 32'(exp_a));
            end
        end
        if (wr_b === 1'b1) begin
            wr_cnt_b++;
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_write got %06h expected no write", data_b);
            end else begin
                exp_b = q_b.pop_front();
                check("b_data", 32'(data_b), 32'(exp_b));
            end
        end
        if (watch_cont && (busy_a !== 1'b1 || done_a !== 1'b0 || busy_b !== 1'b1 || done_b !== 1'b0))
            cont_bad++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle_check();
        if (chk_idle) begin
            check("a_idle_after_link_loss", 32'(busy_a), 32'd0);
            check("b_idle_after_link_loss", 32'(busy_b), 32'd0);
            chk_idle = 1'b0;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        idle(3);
        reset = 1'b1;
    endtask

    // One frame: vsync pulse, back porch, then `lines` lines of 128 pixels with 6-cycle blanking
    task automatic send_frame(input int lines, input bit cap);
        bit in_a, in_b;
        cap_on = cap;
        for (int i = 0; i < 3; i++) begin @(negedge clk); vsync = 1'b1; de = 1'b0; end
        for (int i = 0; i < 3; i++) begin @(negedge clk); vsync = 1'b0; end
        for (int y = 0; y < lines; y++) begin
            for (int x = 0; x < 128; x++) begin
                @(negedge clk);
                idle_check();
                de    = 1'b1;
                red   = 8'(x);
                green = 8'(y);
                blue  = 8'(fid);
                if (y == kill_line && x == kill_x) begin
                    red_vld  = 1'b0;
                    cap_on   = 1'b0;
                    chk_idle = 1'b1;
                end
                in_a = (x < 64) && (y < 4);
                in_b = (x >= 10) && (x < 14) && (y >= 2) && (y < 4);
                fifo_full = 1'b0;
                if (cap_on && in_a && full_left > 0) begin
                    fifo_full = 1'b1;
                    full_left--;
                end
                if (cap_on && in_a && !fifo_full) q_a.push_back({8'(x), 8'(y), 8'(fid)});
                if (cap_on && in_b && !fifo_full) q_b.push_back({8'(x), 8'(y), 8'(fid)});
            end
            for (int h = 0; h < 6; h++) begin
                @(negedge clk);
                idle_check();
                de        = 1'b0;
                fifo_full = 1'b0;
                hsync     = (h >= 1 && h < 3);
            end
        end
        fid++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; hsync = 1'b0; vsync = 1'b0; de = 1'b0;
        red_vld = 1'b1; green_vld = 1'b1; blue_vld = 1'b1;
        red_rdy = 1'b1; green_rdy = 1'b1; blue_rdy = 1'b1;
        red = '0; green = '0; blue = '0;
        enable = 1'b0; single_shot = 1'b0; clear = 1'b0; fifo_full = 1'b0;
        idle(4);
        check("rst_wr_en", 32'(wr_a), 32'd0);
        check("rst_data", 32'(data_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_overflow", 32'(ovf_a), 32'd0);
        check("rst_short", 32'(short_a), 32'd0);
        check("rst_frame_count", 32'(fc_a), 32'd0);
        check("rst_drop_count", 32'(dc_a), 32'd0);
        reset = 1'b1;
        idle(2);

        // Single shot: 64x4 -> 256 writes, 4x2 at (10,2) -> x 10..13 on lines 2,3
        enable = 1'b1; single_shot = 1'b1;
        idle(3);
        check("ss_busy_waiting", 32'(busy_a), 32'd1);
        send_frame(16, 1'b1);
        idle(4);
        check("ss_done", 32'(done_a), 32'd1);
        check("ss_busy_after", 32'(busy_a), 32'd0);
        check("ss_writes_a", 32'(wr_cnt_a), 32'd256);
        check("ss_writes_b", 32'(wr_cnt_b), 32'd8);
        check("ss_frame_count_a", 32'(fc_a), STATS ? 32'd1 : 32'd0);
        check("ss_frame_count_b", 32'(fc_b), STATS ? 32'd1 : 32'd0);
        send_frame(16, 1'b0);
        idle(4);
        check("done_ignores_frame", 32'(wr_cnt_a), 32'd256);
        check("done_holds", 32'(done_a), 32'd1);
        enable = 1'b0;
        idle(2);
        check("done_released", 32'(done_a), 32'd0);

        // Backpressure on the first 5 window pixels
        enable = 1'b1; single_shot = 1'b1; full_left = 5;
        idle(3);
        send_frame(16, 1'b1);
        idle(4);
        check("ovf_set_a", 32'(ovf_a), 32'd1);
        check("ovf_clear_b", 32'(ovf_b), 32'd0);
        check("drop_count_a", 32'(dc_a), STATS ? 32'd5 : 32'd0);
        check("ovf_writes_a", 32'(wr_cnt_a), 32'd507);
        check("ovf_frame_count", 32'(fc_a), STATS ? 32'd2 : 32'd0);
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        check("clear_ovf", 32'(ovf_a), 32'd0);
        check("clear_drop", 32'(dc_a), 32'd0);
        enable = 1'b0;

        // Continuous mode over 3 frames
        apply_reset();
        idle(2);
        check("reset_frame_count", 32'(fc_a), 32'd0);
        base_a = wr_cnt_a; base_b = wr_cnt_b;
        enable = 1'b1; single_shot = 1'b0;
        idle(3);
        watch_cont = 1'b1;
        repeat (3) send_frame(16, 1'b1);
        idle(4);
        watch_cont = 1'b0;
        check("cont_busy_no_done", 32'(cont_bad), 32'd0);
        check("cont_frame_count", 32'(fc_a), STATS ? 32'd3 : 32'd0);
        check("cont_writes_a", 32'(wr_cnt_a - base_a), 32'd768);
        check("cont_writes_b", 32'(wr_cnt_b - base_b), 32'd24);

        // Link loss on line 1 pixel 20, then recovery at the next frame
        base_a = wr_cnt_a; base_b = wr_cnt_b;
        kill_line = 1; kill_x = 20;
        send_frame(16, 1'b1);
        kill_line = -1; kill_x = -1;
        red_vld = 1'b1;
        idle(3);
        check("link_rearmed", 32'(busy_a), 32'd1);
        check("link_writes_a", 32'(wr_cnt_a - base_a), 32'd84);
        check("link_writes_b", 32'(wr_cnt_b - base_b), 32'd0);
        check("link_frame_count", 32'(fc_a), STATS ? 32'd3 : 32'd0);
        send_frame(16, 1'b1);
        idle(4);
        check("link_resume_a", 32'(wr_cnt_a - base_a), 32'd340);
        check("link_resume_fc", 32'(fc_a), STATS ? 32'd4 : 32'd0);

        // Short frame: vsync after 2 of 4 window lines
        enable = 1'b0;
        idle(2);
        apply_reset();
        base_a = wr_cnt_a; base_b = wr_cnt_b;
        enable = 1'b1; single_shot = 1'b1;
        idle(3);
        send_frame(2, 1'b1);
        send_frame(16, 1'b1);
        idle(4);
        check("short_a", 32'(short_a), STATS ? 32'd1 : 32'd0);
        check("short_b", 32'(short_b), STATS ? 32'd1 : 32'd0);
        check("short_done", 32'(done_a), 32'd1);
        check("short_frame_count", 32'(fc_a), STATS ? 32'd1 : 32'd0);
        check("short_writes_a", 32'(wr_cnt_a - base_a), 32'd384);
        check("short_writes_b", 32'(wr_cnt_b - base_b), 32'd8);
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        check("short_cleared", 32'(short_a), 32'd0);
        check("queue_a_drained", 32'(q_a.size()), 32'd0);
        check("queue_b_drained", 32'(q_b.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
